// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures the high time of an asynchronous pulse in whole
// microseconds and presents it with a valid/ack handshake.
// Optional build macro PERIOD_MEAS_EN adds rising-to-rising period measurement.
module pulse_width_meter #(
  parameter int CLK_FREQ = 36,
  parameter int WIDTH    = 16,
  parameter int MAX_US   = 65535
) (
  input  logic             clk_36MHz,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  input  logic             ack,
  output logic [WIDTH-1:0] width_us,
  output logic             timeout,
  output logic             valid,
  output logic             busy,
  output logic [WIDTH-1:0] period_us
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    MEASURE,
    LOW_PHASE,
    DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] count;
  logic             sync1, sync2, sync3;
  logic             rise, fall;
  logic             wrap, sat;
  logic [WIDTH-1:0] count_next;

  // Synchroniser and edge-detect copy; left unreset so a level already high at
  // reset release is seen as high and never mistaken for a fresh rising edge.
  always_ff @(posedge clk_36MHz) begin
    sync1 <= sig_in;
    sync2 <= sync1;
    sync3 <= sync2;
  end

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;

  // The current cycle is counted too, so a pulse of N cycles advances the
  // prescaler exactly N times before the result is latched.
  assign wrap       = (presc == PW'(CLK_FREQ - 1));
  assign count_next = count + {{(WIDTH-1){1'b0}}, wrap};
  // Saturate as soon as the microsecond count would reach MAX_US.
  assign sat        = wrap && (count == WIDTH'(MAX_US - 1));

`ifdef PERIOD_MEAS_EN
  logic [WIDTH-1:0] period_q;
  assign period_us = period_q;
`else
  assign period_us = '0;
`endif

  // Measurement FSM with registered outputs; reset and en=0 abort everything.
  always_ff @(posedge clk_36MHz) begin
    if (!reset || !en) begin
      state    <= IDLE;
      presc    <= '0;
      count    <= '0;
      width_us <= '0;
      timeout  <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
`ifdef PERIOD_MEAS_EN
      period_q <= '0;
`endif
    end else begin
      case (state)
        // Never start on a pulse that is already high.
        IDLE: begin
          if (!sync2) state <= ARMED;
        end
        ARMED: begin
          if (rise) begin
            presc <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          presc <= wrap ? '0 : presc + PW'(1);
          count <= count_next;
          if (sat) begin
            width_us <= WIDTH'(MAX_US);
            timeout  <= 1'b1;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else if (fall) begin
            width_us <= count_next;
            timeout  <= 1'b0;
`ifdef PERIOD_MEAS_EN
            state    <= LOW_PHASE;
`else
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
`endif
          end
        end
`ifdef PERIOD_MEAS_EN
        // The same prescaler/counter keep running from the original rising edge.
        LOW_PHASE: begin
          presc <= wrap ? '0 : presc + PW'(1);
          count <= count_next;
          if (sat) begin
            period_q <= WIDTH'(MAX_US);
            timeout  <= 1'b1;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else if (rise) begin
            period_q <= count_next;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
`endif
        // Hold the result until acknowledged; edges here are ignored.
        DONE: begin
          if (valid && ack) begin
            valid <= 1'b0;
            state <= sync2 ? IDLE : ARMED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Randomised self-checking bench for pulse_width_meter (default build, MAX_US=100).
module tb_pulse_width_meter;

  localparam int CF      = 36;
  localparam int MX      = 100;
  localparam int SAT_CYC = CF * MX;
  localparam int SYNC    = 3;

  logic        clk_36MHz = 1'b0;
  logic        reset, en, sig_in, ack;
  logic [15:0] width_us, period_us;
  logic        timeout, valid, busy;

  int n_cmp = 0;
  int n_err = 0;

  pulse_width_meter #(.CLK_FREQ(CF), .WIDTH(16), .MAX_US(MX)) dut (
    .clk_36MHz(clk_36MHz),
    .reset    (reset),
    .en       (en),
    .sig_in   (sig_in),
    .ack      (ack),
    .width_us (width_us),
    .timeout  (timeout),
    .valid    (valid),
    .busy     (busy),
    .period_us(period_us)
  );

  always #5 clk_36MHz = ~clk_36MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: a pulse of hi cycles reads floor(hi/CF) us, or MAX with timeout
  // once the high time reaches MX microseconds.
  task automatic run_pulse(input int hi, input int ack_dly);
    int  exp_w, exp_t, vlen;
    bit  seen;
    exp_t = (hi >= SAT_CYC) ? 1 : 0;
    exp_w = exp_t ? MX : hi / CF;
    @(posedge clk_36MHz); #1 sig_in = 1'b1;
    repeat (hi) @(posedge clk_36MHz);
    #1;
    check("busy_in_pulse", 32'(busy), 32'(hi >= SYNC && hi < SAT_CYC + SYNC));
    sig_in = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk_36MHz);
      if (valid) seen = 1'b1;
    end
    if (!seen) begin
      check("valid_wait", 32'(valid), 32'd1);
      return;
    end
    check("width", 32'(width_us), 32'(exp_w));
    check("timeout", 32'(timeout), 32'(exp_t));
`ifndef PERIOD_MEAS_EN
    check("period", 32'(period_us), 32'd0);
`endif
    vlen = 0;
    for (int k = 0; k < 50; k++) begin
      if (!valid) break;
      vlen++;
      ack = (k == ack_dly);
      @(negedge clk_36MHz);
    end
    ack = 1'b0;
    check("valid_len", 32'(vlen), 32'(ack_dly + 1));
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, hi, ad;
    reset = 1'b0; en = 1'b0; sig_in = 1'b0; ack = 1'b0;
    repeat (5) @(posedge clk_36MHz);
    @(negedge clk_36MHz);
    check("rst_width", 32'(width_us), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_period", 32'(period_us), 32'd0);
    @(posedge clk_36MHz); #1 reset = 1'b1; en = 1'b1;
    repeat (8) @(posedge clk_36MHz);

    // Directed boundaries around whole microseconds.
    run_pulse(360, 1);
    run_pulse(359, 0);
    run_pulse(35, 2);

    // Saturation while sig stays high: latency, result, no rearm while high.
    @(posedge clk_36MHz); #1 sig_in = 1'b1;
    lat = 0;
    while (!valid && lat < 4000) begin
      @(posedge clk_36MHz); #1;
      lat++;
    end
    check("sat_latency", 32'(lat), 32'(SAT_CYC + SYNC));
    check("sat_width", 32'(width_us), 32'(MX));
    check("sat_timeout", 32'(timeout), 32'd1);
    ack = 1'b1;
    @(posedge clk_36MHz); #1 ack = 1'b0;
    check("sat_ack_valid", 32'(valid), 32'd0);
    repeat (200) @(posedge clk_36MHz);
    #1;
    check("sat_hold_valid", 32'(valid), 32'd0);
    check("sat_hold_busy", 32'(busy), 32'd0);
    sig_in = 1'b0;
    repeat (10) @(posedge clk_36MHz);
    run_pulse(180, 1);

    // Pulse already high when enabled is never measured.
    @(posedge clk_36MHz); #1 en = 1'b0; sig_in = 1'b1;
    repeat (20) @(posedge clk_36MHz);
    #1 en = 1'b1;
    repeat (100) @(posedge clk_36MHz);
    #1 sig_in = 1'b0;
    repeat (15) @(posedge clk_36MHz);
    #1 check("prehigh_no_valid", 32'(valid), 32'd0);
    run_pulse(72, 1);

    // en dropped mid-pulse: nothing reported, next pulse fine.
    @(posedge clk_36MHz); #1 sig_in = 1'b1;
    repeat (200) @(posedge clk_36MHz);
    #1 en = 1'b0;
    @(posedge clk_36MHz); #1;
    check("endrop_valid", 32'(valid), 32'd0);
    check("endrop_busy", 32'(busy), 32'd0);
    check("endrop_width", 32'(width_us), 32'd0);
    repeat (520) @(posedge clk_36MHz);
    #1 sig_in = 1'b0;
    repeat (5) @(posedge clk_36MHz);
    #1 en = 1'b1;
    repeat (10) @(posedge clk_36MHz);
    run_pulse(180, 1);

    // Reset pulse mid-pulse: same outcome.
    @(posedge clk_36MHz); #1 sig_in = 1'b1;
    repeat (200) @(posedge clk_36MHz);
    #1 reset = 1'b0;
    @(posedge clk_36MHz); #1 reset = 1'b1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_width", 32'(width_us), 32'd0);
    repeat (520) @(posedge clk_36MHz);
    #1 sig_in = 1'b0;
    repeat (15) @(posedge clk_36MHz);
    #1 check("rstmid_no_valid", 32'(valid), 32'd0);
    run_pulse(180, 3);

    // A second pulse while the result is held does not disturb it.
    @(posedge clk_36MHz); #1 sig_in = 1'b1;
    repeat (180) @(posedge clk_36MHz);
    #1 sig_in = 1'b0;
    repeat (10) @(posedge clk_36MHz);
    #1 check("hold_valid", 32'(valid), 32'd1);
    sig_in = 1'b1;
    repeat (72) @(posedge clk_36MHz);
    #1 sig_in = 1'b0;
    repeat (10) @(posedge clk_36MHz);
    #1;
    check("hold_valid2", 32'(valid), 32'd1);
    check("hold_width", 32'(width_us), 32'd5);
    check("hold_timeout", 32'(timeout), 32'd0);
    ack = 1'b1;
    @(posedge clk_36MHz); #1 ack = 1'b0;
    check("hold_ack", 32'(valid), 32'd0);
    repeat (5) @(posedge clk_36MHz);
    run_pulse(108, 0);

    // Random pulses and ack delays against the reference.
    for (int i = 0; i < 16; i++) begin
      hi = (i % 6 == 5) ? int'($urandom_range(3590, 3700)) : int'($urandom_range(3, 1500));
      ad = int'($urandom_range(0, 4));
      run_pulse(hi, ad);
      repeat (int'($urandom_range(5, 30))) @(posedge clk_36MHz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
